life_gen_sequencer: RTL and testbench
=====================================

// Module: life_gen_sequencer
// PURPOSE
//  Sequences one Game-of-Life generation over the board memory (ROWS words of COLS cells, 1 = alive).
//  Reads each row once, computes the next state, and writes it back in place through the memory's
//  write/select port. The VGA read port is untouched.
//  Holds a 3-row sliding window plus a saved copy of original row 0, so in-place writes never corrupt pending reads.
// PARAMETERS
//  ROWS    4   board rows = memory depth (>=3)
//  COLS    16  cells per row = memory word width; bit 0 = column 0
//  ADDR_W  2   row address width, clog2(ROWS)
//  WRAP    1   1 = toroidal board (row and column edges wrap); 0 = cells beyond the edge are dead
//  CNT_W   16  generation counter width
// PORTS
//  clk        in   1       single clock, all state on rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  start      in   1       request one generation; sampled only in IDLE
//  hold       in   1       freeze sequencer in place (pause / debug load)
//  busy       out  1       high from the cycle after start is accepted until DONE completes
//  done       out  1       one-cycle pulse when the last row has been written
//  gen_count  out  CNT_W   generations completed, wraps modulo 2^CNT_W
//  rd_addr    out  ADDR_W  memory read row address
//  rd_data    in   COLS    row data, valid the cycle after rd_addr is presented (registered-address read)
//  wr_en      out  1       memory write strobe
//  wr_addr    out  ADDR_W  memory write row address
//  wr_data    out  COLS    next-generation row
// BEHAVIOUR
//  Reset: state IDLE; row counter, window regs, row0 copy, gen_count all 0; every output 0.
//  Reset is asynchronous, so it takes effect mid-generation at once. A partly updated board is left as is (no rollback).
//  FSM, one state per cycle unless hold:
//   IDLE     busy=0. If start: go to RD_CUR. Otherwise stay.
//   RD_CUR   rd_addr=0.
//   RD_PREV  cur<=rd_data; row0<=rd_data; rd_addr=ROWS-1.
//   CAP_PREV prev <= WRAP ? rd_data : 0; r<=0.
//   FETCH    rd_addr=r+1 (held at r when r=ROWS-1; data unused).
//   COMPUTE  nxt = (r==ROWS-1) ? (WRAP ? row0 : 0) : rd_data.
//            wr_en=1, wr_addr=r, wr_data=life(prev,cur,nxt).
//            Then prev<=cur, cur<=nxt. If r==ROWS-1 go to DONE; otherwise r<=r+1 and go to FETCH.
//   DONE     done=1; gen_count<=gen_count+1; next state IDLE.
//  life(): per column c, n = alive count of the 8 neighbours (cols c-1, c, c+1 across prev/cur/nxt, excluding cur[c]).
//   Neighbour columns -1 and COLS map to COLS-1 and 0 if WRAP, else read as 0.
//   New cell = (n==3) | (cur[c] & n==2). n is 4 bits wide; no overflow is possible.
//  Latency: start sampled high in IDLE at edge T.
//   wr_en high at T+5, T+7, ... T+3+2*ROWS with wr_addr 0..ROWS-1.
//   done high at T+4+2*ROWS. ROWS=4: 12 cycles.
//  busy is 1 in every non-IDLE state, including DONE. busy falls the cycle after done.
//  start while busy is ignored and not queued. start in the same cycle DONE returns to IDLE is also ignored.
//  hold=1: state, r, window, row0 and gen_count are frozen. wr_en and done are forced to 0.
//   rd_addr keeps its current value, so rd_data stays valid across the pause.
//   When hold releases, the interrupted state executes normally. hold in IDLE blocks acceptance of start.
//  wr_addr and wr_data are driven only while wr_en=1 and are 0 otherwise. rd_addr is 0 in IDLE.
// TESTING (ROWS=4, COLS=16 unless noted)
//  1 WRAP=0, rows {0x0020,0x0020,0x0020,0x0000}, pulse start
//    -> rows become {0x0000,0x0070,0x0000,0x0000}; a second start restores the original rows.
//  2 WRAP=0, block rows {0x0000,0x0060,0x0060,0x0000}
//    -> unchanged after 3 generations; gen_count=3.
//  3 Edge wrap, rows {0x8003,0,0,0}
//    -> WRAP=1: {0x0001,0x0001,0x0000,0x0001}; WRAP=0: all rows 0x0000.
//  4 Timing: start at T
//    -> wr_en at T+5/7/9/11 with wr_addr 0/1/2/3; done at T+12 only.
//    -> A start pulse at T+6 is ignored; gen_count increments by exactly 1.
//  5 hold high 3 cycles while in COMPUTE for r=1
//    -> no wr_en during hold; done at T+15; final board identical to scenario 1.
//  6 rst_n low during FETCH
//    -> busy/done/wr_en/gen_count=0 immediately.
//    -> The next start runs a full 12-cycle generation from row 0.

Source files
------------

// File: rtl/life_gen_sequencer_if.sv
// Handshake and board-memory port bundle for the Game-of-Life generation sequencer.
// The master side is the sequencer; the slave side is its controller plus the board memory.
interface life_gen_sequencer_if #(
    parameter int COLS   = 16,
    parameter int ADDR_W = 2,
    parameter int CNT_W  = 16
);
    logic              start;
    logic              hold;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  gen_count;
    logic [ADDR_W-1:0] rd_addr;
    logic [COLS-1:0]   rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [COLS-1:0]   wr_data;

    modport master (
        input  start, hold, rd_data,
        output busy, done, gen_count, rd_addr, wr_en, wr_addr, wr_data
    );

    modport slave (
        output start, hold, rd_data,
        input  busy, done, gen_count, rd_addr, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/life_gen_sequencer.sv
// Runs one Game-of-Life generation in place over a ROWS x COLS board memory using a
// three-row sliding window plus a saved copy of the original row 0.
module life_gen_sequencer #(
    parameter int ROWS   = 4,
    parameter int COLS   = 16,
    parameter int ADDR_W = 2,
    parameter int WRAP   = 1,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    life_gen_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_CUR   = 3'd1,
        S_RD_PREV  = 3'd2,
        S_CAP_PREV = 3'd3,
        S_FETCH    = 3'd4,
        S_COMPUTE  = 3'd5,
        S_DONE     = 3'd6
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] r_q, r_d;
    logic [COLS-1:0]   prev_q, prev_d;
    logic [COLS-1:0]   cur_q, cur_d;
    logic [COLS-1:0]   row0_q, row0_d;
    logic [CNT_W-1:0]  gen_q, gen_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;

    logic [ADDR_W-1:0] addr_s;
    logic [COLS-1:0]   nxt_s;
    logic [COLS-1:0]   life_s;
    logic              wr_en_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [COLS-1:0]   wr_data_s;
    logic              done_s;

    // Row padded with the column -1 (bit 0) and column COLS (top bit) neighbours.
    function automatic logic [COLS+1:0] ext_row(input logic [COLS-1:0] row);
        if (WRAP != 0) begin
            ext_row = {row[0], row, row[COLS-1]};
        end else begin
            ext_row = {1'b0, row, 1'b0};
        end
    endfunction

    function automatic logic [COLS-1:0] life_row(input logic [COLS-1:0] p,
                                                 input logic [COLS-1:0] c,
                                                 input logic [COLS-1:0] n);
        logic [COLS+1:0] pe, ce, ne;
        logic [3:0]      cnt;
        pe = ext_row(p);
        ce = ext_row(c);
        ne = ext_row(n);
        life_row = {COLS{1'b0}};
        for (int i = 0; i < COLS; i++) begin
            cnt = {3'b000, pe[i]} + {3'b000, pe[i+1]} + {3'b000, pe[i+2]}
                + {3'b000, ce[i]}                     + {3'b000, ce[i+2]}
                + {3'b000, ne[i]} + {3'b000, ne[i+1]} + {3'b000, ne[i+2]};
            life_row[i] = (cnt == 4'd3) | (c[i] & (cnt == 4'd2));
        end
    endfunction

    // Next-state, window update and output decode; hold overrides everything at the end.
    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        prev_d      = prev_q;
        cur_d       = cur_q;
        row0_d      = row0_q;
        gen_d       = gen_q;
        addr_s      = {ADDR_W{1'b0}};
        wr_en_s     = 1'b0;
        wr_addr_s   = {ADDR_W{1'b0}};
        wr_data_s   = {COLS{1'b0}};
        done_s      = 1'b0;
        // The last row's lower neighbour is the saved original row 0, never the rewritten one.
        if (r_q == LAST_ROW) begin
            nxt_s = (WRAP != 0) ? row0_q : {COLS{1'b0}};
        end else begin
            nxt_s = bus.rd_data;
        end
        life_s = life_row(prev_q, cur_q, nxt_s);

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RD_CUR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD_CUR: begin
                addr_s  = {ADDR_W{1'b0}};
                state_d = S_RD_PREV;
            end
            S_RD_PREV: begin
                addr_s  = LAST_ROW;
                cur_d   = bus.rd_data;
                row0_d  = bus.rd_data;
                state_d = S_CAP_PREV;
            end
            S_CAP_PREV: begin
                addr_s  = LAST_ROW;
                prev_d  = (WRAP != 0) ? bus.rd_data : {COLS{1'b0}};
                r_d     = {ADDR_W{1'b0}};
                state_d = S_FETCH;
            end
            S_FETCH, S_COMPUTE: begin
                addr_s = (r_q == LAST_ROW) ? r_q : (r_q + ADDR_ONE);
                if (state_q == S_COMPUTE) begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = r_q;
                    wr_data_s = life_s;
                    prev_d    = cur_q;
                    cur_d     = nxt_s;
                    if (r_q == LAST_ROW) begin
                        state_d = S_DONE;
                    end else begin
                        r_d     = r_q + ADDR_ONE;
                        state_d = S_FETCH;
                    end
                end else begin
                    state_d = S_COMPUTE;
                end
            end
            S_DONE: begin
                done_s  = 1'b1;
                gen_d   = gen_q + CNT_ONE;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Re-present the previous address so the registered-address memory keeps returning
        // the row the frozen state is waiting on, whichever state is paused.
        if (bus.hold) begin
            state_d   = state_q;
            r_d       = r_q;
            prev_d    = prev_q;
            cur_d     = cur_q;
            row0_d    = row0_q;
            gen_d     = gen_q;
            addr_s    = last_addr_q;
            wr_en_s   = 1'b0;
            wr_addr_s = {ADDR_W{1'b0}};
            wr_data_s = {COLS{1'b0}};
            done_s    = 1'b0;
        end else begin
            state_d = state_d;
        end
        last_addr_d = addr_s;
    end

    // Sequencer state, window rows, row-0 copy and generation counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            r_q         <= {ADDR_W{1'b0}};
            prev_q      <= {COLS{1'b0}};
            cur_q       <= {COLS{1'b0}};
            row0_q      <= {COLS{1'b0}};
            gen_q       <= {CNT_W{1'b0}};
            last_addr_q <= {ADDR_W{1'b0}};
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            prev_q      <= prev_d;
            cur_q       <= cur_d;
            row0_q      <= row0_d;
            gen_q       <= gen_d;
            last_addr_q <= last_addr_d;
        end
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = done_s;
    assign bus.gen_count = gen_q;
    assign bus.rd_addr   = addr_s;
    assign bus.wr_en     = wr_en_s;
    assign bus.wr_addr   = wr_addr_s;
    assign bus.wr_data   = wr_data_s;

endmodule

// File: tb/tb_life_gen_sequencer.sv
// Bench: WRAP=0 and WRAP=1 sequencers run in lockstep over their own board memories,
// compared against a whole-board Game-of-Life reference and the latency rules.
module tb_life_gen_sequencer;
    localparam int ROWS      = 4;
    localparam int COLS      = 16;
    localparam int ADDR_W    = 2;
    localparam int CNT_W     = 16;
    localparam int BW        = ROWS * COLS;
    localparam int LAST_STEP = 4 + 2 * ROWS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_s = 1'b0;
    logic hold_s = 1'b0;
    logic ld_en = 1'b0;
    logic [ADDR_W-1:0] ld_addr = '0;
    logic [COLS-1:0]   ld_data = '0;

    int n_checks = 0;
    int n_fail = 0;
    int exp_gen = 0;
    logic [BW-1:0] model0, model1;

    always #5 clk = ~clk;

    life_gen_sequencer_if #(.COLS(COLS), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus0 ();
    life_gen_sequencer_if #(.COLS(COLS), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus1 ();

    life_gen_sequencer #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W), .WRAP(0), .CNT_W(CNT_W))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.master));
    life_gen_sequencer #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W), .WRAP(1), .CNT_W(CNT_W))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.master));

    // Board memories with registered read address.
    logic [COLS-1:0]   mem0 [ROWS];
    logic [COLS-1:0]   mem1 [ROWS];
    logic [ADDR_W-1:0] ra0_q, ra1_q;
    always @(posedge clk) begin
        if (ld_en) begin
            mem0[ld_addr] <= ld_data;
            mem1[ld_addr] <= ld_data;
        end else begin
            if (bus0.wr_en) mem0[bus0.wr_addr] <= bus0.wr_data;
            if (bus1.wr_en) mem1[bus1.wr_addr] <= bus1.wr_data;
        end
        ra0_q <= bus0.rd_addr;
        ra1_q <= bus1.rd_addr;
    end
    assign bus0.rd_data = mem0[ra0_q];
    assign bus1.rd_data = mem1[ra1_q];
    assign bus0.start = start_s;
    assign bus1.start = start_s;
    assign bus0.hold  = hold_s;
    assign bus1.hold  = hold_s;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Whole-board reference: count the eight neighbours of every cell directly.
    function automatic logic [BW-1:0] ref_gen(input logic [BW-1:0] b, input bit wrap);
        logic [BW-1:0] nb;
        int n, rr, cc;
        nb = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr != 0 || dc != 0) begin
                            rr = r + dr;
                            cc = c + dc;
                            if (wrap) begin
                                rr = (rr + ROWS) % ROWS;
                                cc = (cc + COLS) % COLS;
                                n += int'(b[rr*COLS+cc]);
                            end else if (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS) begin
                                n += int'(b[rr*COLS+cc]);
                            end
                        end
                    end
                end
                nb[r*COLS+c] = (n == 3) || (b[r*COLS+c] && n == 2);
            end
        end
        return nb;
    endfunction

    task automatic load_board(input logic [BW-1:0] b);
        for (int r = 0; r < ROWS; r++) begin
            @(posedge clk); #1;
            ld_en = 1'b1;
            ld_addr = ADDR_W'(r);
            ld_data = b[r*COLS +: COLS];
        end
        @(posedge clk); #1;
        ld_en = 1'b0;
        model0 = b;
        model1 = b;
    endtask

    task automatic check_board(input string tag);
        for (int r = 0; r < ROWS; r++) begin
            check_eq($sformatf("%s_w0_row%0d", tag, r), 64'(mem0[r]), 64'(model0[r*COLS +: COLS]));
            check_eq($sformatf("%s_w1_row%0d", tag, r), 64'(mem1[r]), 64'(model1[r*COLS +: COLS]));
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_gen = 0;
    endtask

    // One generation. Cycle k lies between edges T+k-1 and T+k; step = 1 + active cycles so far.
    task automatic run_gen(input int hold_lo, input int hold_hi, input bit rand_hold,
                           input bit rand_start, input int start_k, input int abort_step,
                           output int done_k);
        logic [BW-1:0] nx0, nx1;
        int step, row;
        bit h, exp_wr;
        nx0 = ref_gen(model0, 1'b0);
        nx1 = ref_gen(model1, 1'b1);
        done_k = -1;
        step = 1;
        @(posedge clk); #1;
        start_s = 1'b1;
        hold_s = 1'b0;
        for (int k = 1; k < 200 && step <= LAST_STEP + 1; k++) begin
            @(posedge clk); #1;
            if (step == abort_step) begin
                rst_n = 1'b0;
                #1;
                check_eq("rst_busy", {bus1.busy, bus0.busy}, 2'b00);
                check_eq("rst_done", {bus1.done, bus0.done}, 2'b00);
                check_eq("rst_wr_en", {bus1.wr_en, bus0.wr_en}, 2'b00);
                check_eq("rst_gen0", 64'(bus0.gen_count), 64'd0);
                check_eq("rst_gen1", 64'(bus1.gen_count), 64'd0);
                for (int r = 0; r < ROWS; r++) begin
                    if (5 + 2 * r < step) begin
                        model0[r*COLS +: COLS] = nx0[r*COLS +: COLS];
                        model1[r*COLS +: COLS] = nx1[r*COLS +: COLS];
                    end
                end
                exp_gen = 0;
                start_s = 1'b0;
                hold_s = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
            h = (k >= hold_lo && k <= hold_hi) ||
                (rand_hold && step <= LAST_STEP && $urandom_range(0, 3) == 0);
            hold_s = h;
            if (step <= LAST_STEP) begin
                start_s = rand_start ? 1'($urandom_range(0, 1)) : (k == start_k);
            end else begin
                start_s = 1'b0;
            end
            @(negedge clk);
            exp_wr = !h && step >= 5 && step <= 3 + 2 * ROWS && (step % 2) == 1;
            row = (step - 5) / 2;
            check_eq("busy", {bus1.busy, bus0.busy}, (step <= LAST_STEP) ? 2'b11 : 2'b00);
            check_eq("wr_en", {bus1.wr_en, bus0.wr_en}, exp_wr ? 2'b11 : 2'b00);
            check_eq("done", {bus1.done, bus0.done}, (!h && step == LAST_STEP) ? 2'b11 : 2'b00);
            if (exp_wr) begin
                check_eq("wr_addr", {bus1.wr_addr, bus0.wr_addr}, {ADDR_W'(row), ADDR_W'(row)});
                check_eq("wr_data_w0", 64'(bus0.wr_data), 64'(nx0[row*COLS +: COLS]));
                check_eq("wr_data_w1", 64'(bus1.wr_data), 64'(nx1[row*COLS +: COLS]));
            end else begin
                check_eq("wr_idle", {bus1.wr_addr, bus0.wr_addr, bus1.wr_data, bus0.wr_data}, 64'd0);
            end
            if (bus0.done && done_k < 0) done_k = k;
            if (!h) step++;
        end
        start_s = 1'b0;
        hold_s = 1'b0;
        check_eq("gen_completes", 64'(step == LAST_STEP + 2), 64'd1);
        model0 = nx0;
        model1 = nx1;
        exp_gen++;
        check_eq("gen_count_w0", 64'(bus0.gen_count), 64'(exp_gen % (1 << CNT_W)));
        check_eq("gen_count_w1", 64'(bus1.gen_count), 64'(exp_gen % (1 << CNT_W)));
    endtask

    initial begin
        int dk;
        logic [BW-1:0] b;
        #3;
        check_eq("reset_ctrl", {bus1.busy, bus0.busy, bus1.done, bus0.done, bus1.wr_en, bus0.wr_en}, 6'd0);
        check_eq("reset_gen", {bus1.gen_count, bus0.gen_count}, 32'd0);
        check_eq("reset_addr", {bus1.rd_addr, bus0.rd_addr, bus1.wr_addr, bus0.wr_addr}, 8'd0);
        check_eq("reset_wdata", {bus1.wr_data, bus0.wr_data}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Blinker, with an ignored start pulse at T+6 and the exact latency.
        b = {16'h0000, 16'h0020, 16'h0020, 16'h0020};
        load_board(b);
        run_gen(-1, -1, 1'b0, 1'b0, 6, -1, dk);
        check_eq("s4_done_cycle", 64'(dk), 64'd12);
        check_eq("s1_rows_w0", {mem0[3], mem0[2], mem0[1], mem0[0]}, 64'h0000_0000_0070_0000);
        check_board("s1a");
        run_gen(-1, -1, 1'b0, 1'b0, -1, -1, dk);
        check_eq("s1_restore_w0", {mem0[3], mem0[2], mem0[1], mem0[0]}, 64'(b));
        check_board("s1b");

        // Block is a still life.
        do_reset();
        b = {16'h0000, 16'h0060, 16'h0060, 16'h0000};
        load_board(b);
        for (int i = 0; i < 3; i++) run_gen(-1, -1, 1'b0, 1'b0, -1, -1, dk);
        check_eq("s2_block_w0", {mem0[3], mem0[2], mem0[1], mem0[0]}, 64'(b));
        check_eq("s2_gen_count", 64'(bus0.gen_count), 64'd3);

        // Edge wrap.
        b = {16'h0000, 16'h0000, 16'h0000, 16'h8003};
        load_board(b);
        run_gen(-1, -1, 1'b0, 1'b0, -1, -1, dk);
        check_eq("s3_wrap1", {mem1[3], mem1[2], mem1[1], mem1[0]}, 64'h0001_0000_0001_0001);
        check_eq("s3_wrap0", {mem0[3], mem0[2], mem0[1], mem0[0]}, 64'd0);

        // Hold for three cycles in COMPUTE of row 1.
        b = {16'h0000, 16'h0020, 16'h0020, 16'h0020};
        load_board(b);
        run_gen(7, 9, 1'b0, 1'b0, -1, -1, dk);
        check_eq("s5_done_cycle", 64'(dk), 64'd15);
        check_eq("s5_rows_w0", {mem0[3], mem0[2], mem0[1], mem0[0]}, 64'h0000_0000_0070_0000);

        // Reset in the FETCH of row 2 leaves rows 0-1 updated; the next run starts from row 0.
        b = {$urandom(), $urandom()};
        load_board(b);
        run_gen(-1, -1, 1'b0, 1'b0, -1, 8, dk);
        check_board("s6_partial");
        run_gen(-1, -1, 1'b0, 1'b0, -1, -1, dk);
        check_eq("s6_done_cycle", 64'(dk), 64'd12);
        check_board("s6_full");

        // Hold in IDLE blocks start.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            hold_s = 1'b1;
            start_s = 1'b1;
            @(negedge clk);
            check_eq("idle_hold_busy", {bus1.busy, bus0.busy}, 2'b00);
        end
        @(posedge clk); #1;
        hold_s = 1'b0;
        start_s = 1'b0;
        @(negedge clk);
        check_eq("idle_hold_after", {bus1.busy, bus0.busy}, 2'b00);

        // Random boards with random hold and start noise.
        for (int i = 0; i < 20; i++) begin
            b = {$urandom(), $urandom()};
            load_board(b);
            run_gen(-1, -1, 1'b1, 1'b1, -1, -1, dk);
            check_board("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
